foobar: RTL and testbench
=========================

Name: foobar

Overview:
- Dual-rate event generator for the foo/bar demo datapath.
- While enabled, it emits a one-cycle `foo` pulse on every FOO_DIV-th enabled cycle and a one-cycle `bar` pulse on every BAR_DIV-th enabled cycle.
- It keeps running totals of the pulses in `count_foo` and `count_bar`.
- All state is synchronous to a single clock with synchronous active-high reset.

Parameters:
- FOO_DIV, 3: enabled-cycle period of `foo` pulses. Legal range 1..255.
- BAR_DIV, 5: enabled-cycle period of `bar` pulses. Legal range 1..255.
- CNT_W, 8: width of `count_foo` and `count_bar`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset; one clock, synchronous reset, active-high; overrides `en`.
- en  input  1  enable; each rising edge with en=1 counts as one enabled cycle.
- foo  output  1  registered pulse, high for one cycle per FOO_DIV enabled cycles.
- bar  output  1  registered pulse, high for one cycle per BAR_DIV enabled cycles.
- count_foo  output  CNT_W  number of `foo` pulses since reset.
- count_bar  output  CNT_W  number of `bar` pulses since reset.

Behaviour:
- Internal state:
  - `ph_foo` is a phase counter in 0..FOO_DIV-1.
  - `ph_bar` is a phase counter in 0..BAR_DIV-1.
  - Each is ceil(log2(DIV)) bits wide, minimum 1 bit.
- Reset (rst=1 at a rising edge):
  - `ph_foo`, `ph_bar`, `foo`, `bar`, `count_foo` and `count_bar` all become 0.
  - Reset has priority over `en`.
  - Reset asserted mid-sequence discards the current phase entirely; there is no partial carry-over.
- Enabled edge (rst=0, en=1):
  - `hit_foo` = (ph_foo == FOO_DIV-1). `ph_foo` becomes 0 if `hit_foo`, else ph_foo+1.
  - `foo` takes the value of `hit_foo`. `count_foo` becomes count_foo + `hit_foo`.
  - `bar`, `ph_bar` and `count_bar` update identically using BAR_DIV.
  - Net effect: after reset, the first `foo` pulse is visible after the 3rd enabled edge, then after edges 6, 9, ...; `bar` pulses after edges 5, 10, ...
- Disabled edge (rst=0, en=0):
  - Phases and counts hold.
  - `foo` and `bar` are forced to 0. A pulse never stretches across a disabled cycle.
- Latency: a pulse and its count increment appear in the same cycle, registered, one edge after the qualifying enabled cycle.
- Simultaneous events: `foo` and `bar` may both be high in the same cycle (e.g. enabled edge 15 with the defaults). Both counts increment independently in that cycle.
- DIV=1: the pulse is high on every enabled cycle and the count increments every enabled edge.
- Count overflow: default is modulo 2^CNT_W wrap-around (255+1 → 0).
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro: FOOBAR_SAT_EN.
- Defined: `count_foo` and `count_bar` saturate at 2^CNT_W-1 (255 by default). Further pulses still assert `foo`/`bar` but do not change the saturated count. Reset clears saturated counts to 0.
- Undefined: counts wrap modulo 2^CNT_W as described in Behaviour.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 3 edges, then rst=0 with en=0 for 10 edges.
  - Required: foo=bar=0 and count_foo=count_bar=0 throughout.
- Basic cadence:
  - Stimulus: release reset, then en=1 for 15 edges.
  - Required: foo high after edges 3, 6, 9, 12, 15; bar high after edges 5, 10, 15; both high after edge 15; final count_foo=5, count_bar=3.
- Enable gap:
  - Stimulus: en=1 for 2 edges, en=0 for 4 edges, en=1 for 1 edge.
  - Required: foo=0 during the gap; foo=1 only after the 7th edge overall (the 3rd enabled edge); count_foo=1.
- Reset mid-operation:
  - Stimulus: en=1 for 14 edges, then rst=1 with en=1 for 1 edge, then en=1 for 3 more edges.
  - Required: all outputs 0 after the reset edge; foo=1 and count_foo=1 after the 3rd post-reset edge; count_bar=0.
- Wrap (macro undefined):
  - Stimulus: en=1 for 765 edges, then 3 more.
  - Required: count_foo=255, then count_foo=0 with foo=1 on the 768th edge.
- Saturation (FOOBAR_SAT_EN defined):
  - Stimulus: same as the wrap test.
  - Required: count_foo stays 255; foo still pulses on edge 768.

Source files
------------

// File: rtl/foobar.sv
// foobar: dual-rate foo/bar pulse generator with running pulse counts.
// Define FOOBAR_SAT_EN to make the counts saturate instead of wrapping.
module foobar #(
  parameter int FOO_DIV = 3,
  parameter int BAR_DIV = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             foo,
  output logic             bar,
  output logic [CNT_W-1:0] count_foo,
  output logic [CNT_W-1:0] count_bar
);
  localparam int FW = FOO_DIV > 1 ? $clog2(FOO_DIV) : 1;
  localparam int BW = BAR_DIV > 1 ? $clog2(BAR_DIV) : 1;
  logic [FW-1:0] ph_foo;
  logic [BW-1:0] ph_bar;
  logic hit_foo, hit_bar, inc_foo, inc_bar;
  assign hit_foo = ph_foo == FW'(FOO_DIV - 1);
  assign hit_bar = ph_bar == BW'(BAR_DIV - 1);
`ifdef FOOBAR_SAT_EN
  assign inc_foo = hit_foo && count_foo != '1;
  assign inc_bar = hit_bar && count_bar != '1;
`else
  assign inc_foo = hit_foo;
  assign inc_bar = hit_bar;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_foo <= '0;
      ph_bar <= '0;
      foo <= 1'b0;
      bar <= 1'b0;
      count_foo <= '0;
      count_bar <= '0;
    end else if (en) begin
      ph_foo <= hit_foo ? '0 : ph_foo + 1'b1;
      ph_bar <= hit_bar ? '0 : ph_bar + 1'b1;
      foo <= hit_foo;
      bar <= hit_bar;
      count_foo <= count_foo + CNT_W'(inc_foo);
      count_bar <= count_bar + CNT_W'(inc_bar);
    end else begin
      foo <= 1'b0;
      bar <= 1'b0;
    end
  end
endmodule

// File: tb/tb_foobar.sv
// tb_foobar: scoreboard bench for foobar; expected values come from an enabled-edge-count model.
module tb_foobar;
  localparam int FOO_DIV = 3;
  localparam int BAR_DIV = 5;
  localparam int CNT_W = 8;
  typedef struct {
    logic f;
    logic b;
    logic [CNT_W-1:0] cf;
    logic [CNT_W-1:0] cb;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic foo, bar;
  logic [CNT_W-1:0] count_foo, count_bar;
  exp_t q[$];
  int n = 0;
  int checks = 0;
  int passed = 0;
  foobar #(.FOO_DIV(FOO_DIV), .BAR_DIV(BAR_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .foo(foo), .bar(bar),
    .count_foo(count_foo), .count_bar(count_bar)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask
  function automatic logic [CNT_W-1:0] cnt(input int pulses);
`ifdef FOOBAR_SAT_EN
    return pulses > (1 << CNT_W) - 1 ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(pulses);
`else
    return CNT_W'(pulses % (1 << CNT_W));
`endif
  endfunction
  task automatic step(input logic r, input logic e);
    exp_t x;
    @(negedge clk);
    rst = r;
    en = e;
    if (r) n = 0;
    else if (e) n++;
    x.f = !r && e && (n % FOO_DIV == 0);
    x.b = !r && e && (n % BAR_DIV == 0);
    x.cf = cnt(n / FOO_DIV);
    x.cb = cnt(n / BAR_DIV);
    q.push_back(x);
  endtask
  task automatic run(input logic r, input logic e, input int k);
    for (int i = 0; i < k; i++) step(r, e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      check("foo", 32'(foo), 32'(x.f));
      check("bar", 32'(bar), 32'(x.b));
      check("count_foo", 32'(count_foo), 32'(x.cf));
      check("count_bar", 32'(count_bar), 32'(x.cb));
    end
  end
  initial begin
    run(1, 0, 3);
    run(0, 0, 10);
    run(0, 1, 15);
    run(1, 0, 1);
    run(0, 1, 2);
    run(0, 0, 4);
    run(0, 1, 1);
    run(1, 0, 1);
    run(0, 1, 14);
    run(1, 1, 1);
    run(0, 1, 3);
    run(1, 0, 1);
    run(0, 1, 765);
    run(0, 1, 3);
    run(0, 1, 4);
    run(1, 1, 1);
    run(0, 0, 2);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
